// File: rtl/bus_tx_queue_pkg.sv
// Shared types and defaults for the bus transmit queue.
// FSM state encoding and the default data width used by all bus_tx_queue files.
package bus_tx_queue_pkg;

  localparam int unsigned DEF_N = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    YIELD   = 2'd2
  } state_t;

endpackage

// File: rtl/bus_tx_queue_sync_fifo.sv
// Synchronous FIFO for the transmit queue.
// Holds the storage, the wrapping pointers, a separate word counter and the sticky overflow flag.
module bus_tx_queue_sync_fifo
  import bus_tx_queue_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [N-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [N-1:0]               rd_data,
  output logic                       wr_accept,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;

  // full is taken from the registered count, so a same-cycle pop never frees a slot for a write
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign wr_accept = wr_en & ~full;
  assign pop       = rd_en & ~empty;
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/bus_tx_queue.sv
// Per-device transmit stage in front of the shared tri-state bus.
// Requests the bus while words are queued and yields for one cycle after BURST back-to-back words.
module bus_tx_queue
  import bus_tx_queue_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BURST = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [N-1:0]           wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   req,
  input  logic                   grant,
  output logic [N-1:0]           bus_data,
  output logic                   bus_drive,
  output logic                   sent
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] burst_nxt;
  logic          xfer;
  logic          wr_accept;
  logic [N-1:0]  head;

  assign xfer = req & grant;

  bus_tx_queue_sync_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (xfer),
    .rd_data   (head),
    .wr_accept (wr_accept),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // A transfer that drains the last word (with no refill) returns to IDLE before the burst limit applies
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    unique case (state)
      IDLE: begin
        burst_nxt = '0;
        if (!empty) state_nxt = REQUEST;
      end
      REQUEST: begin
        if (!grant) begin
          burst_nxt = '0;
        end else if (count == CW'(1) && !wr_accept) begin
          state_nxt = IDLE;
          burst_nxt = '0;
        end else if (burst_cnt == BW'(BURST - 1)) begin
          state_nxt = YIELD;
          burst_nxt = '0;
        end else begin
          burst_nxt = burst_cnt + BW'(1);
        end
      end
      YIELD: begin
        burst_nxt = '0;
        state_nxt = empty ? IDLE : REQUEST;
      end
      default: begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
    endcase
  end

  always_comb begin
    req       = 1'b0;
    bus_drive = 1'b0;
    bus_data  = '0;
    req       = (state == REQUEST);
    bus_drive = req & grant;
    bus_data  = bus_drive ? head : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) sent <= 1'b0;
    else     sent <= xfer;
  end

endmodule

// File: tb/tb_bus_tx_queue.sv
// Self-checking bench for bus_tx_queue (N=8, DEPTH=4, BURST=2).
// Expected bus words are queued at write time and compared whenever the DUT drives the bus.
module tb_bus_tx_queue;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       req;
  logic       grant;
  logic [7:0] bus_data;
  logic       bus_drive;
  logic       sent;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  bus_tx_queue #(.N(8), .DEPTH(4), .BURST(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .req       (req),
    .grant     (grant),
    .bus_data  (bus_data),
    .bus_drive (bus_drive),
    .sent      (sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    sb.push_back(d);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(empty && !req) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  // Bus monitor: every driven word must be the oldest outstanding scoreboard entry
  always @(negedge clk) begin
    logic [7:0] exp_w;
    if (bus_drive === 1'b1) begin
      if (sb.size() == 0) begin
        chk("bus_unexpected", 32'd1, 32'd0);
      end else begin
        exp_w = sb.pop_front();
        chk("bus_data", 32'(bus_data), 32'(exp_w));
      end
    end
  end

  initial begin
    logic [7:0] d;
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'h55; grant = 1'b1;

    // 1: reset with writes pending
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_drive", 32'(bus_drive), 32'd0);
    chk("rst_data", 32'(bus_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_sent", 32'(sent), 32'd0);
    rst = 1'b0; wr_en = 1'b0;
    tick();

    // 2: single word latency
    push_word(8'hAA);
    tick();
    wr_en = 1'b0;
    chk("t2_req_t1", 32'(req), 32'd0);
    chk("t2_cnt_t1", 32'(count), 32'd1);
    tick();
    chk("t2_req_t2", 32'(req), 32'd1);
    chk("t2_drive_t2", 32'(bus_drive), 32'd1);
    chk("t2_data_t2", 32'(bus_data), 32'hAA);
    chk("t2_sent_t2", 32'(sent), 32'd0);
    tick();
    chk("t2_sent_t3", 32'(sent), 32'd1);
    chk("t2_req_t3", 32'(req), 32'd0);
    chk("t2_empty_t3", 32'(empty), 32'd1);
    chk("t2_data_t3", 32'(bus_data), 32'd0);
    tick();
    chk("t2_sent_t4", 32'(sent), 32'd0);
    chk("t2_req_t4", 32'(req), 32'd0);

    // 3: burst of two then forced yield
    push_word(8'h11); tick();
    push_word(8'h22); tick();
    push_word(8'h33); tick();
    wr_en = 1'b0;
    chk("t3_drive_22", 32'(bus_drive), 32'd1);
    tick();
    chk("t3_yield_req", 32'(req), 32'd0);
    chk("t3_yield_drive", 32'(bus_drive), 32'd0);
    tick();
    chk("t3_drive_33", 32'(bus_drive), 32'd1);
    tick();
    chk("t3_req_end", 32'(req), 32'd0);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: fill past full with no grant, then dump
    grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'hC0 + i);
      if (i < 4) push_word(d);
      else begin wr_en = 1'b1; wr_data = d; end
      tick();
      if (i == 3) begin
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_cnt4", 32'(count), 32'd4);
        chk("t4_ovf_pre", 32'(overflow), 32'd0);
      end
    end
    wr_en = 1'b0;
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_cnt_hold", 32'(count), 32'd4);
    chk("t4_req_nogrant", 32'(req), 32'd1);
    chk("t4_drive_nogrant", 32'(bus_drive), 32'd0);
    grant = 1'b1;
    drain(20);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);

    // 5: write+pop at full drops the write; at count 3 the count holds
    rst = 1'b1; grant = 1'b0; tick(); rst = 1'b0;
    chk("t5_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      push_word(8'(8'hD0 + i));
      tick();
    end
    wr_en = 1'b1; wr_data = 8'hEE; grant = 1'b1;
    tick();
    chk("t5_cnt_after_full", 32'(count), 32'd3);
    chk("t5_ovf", 32'(overflow), 32'd1);
    push_word(8'hE1);
    tick();
    wr_en = 1'b0;
    chk("t5_cnt_hold3", 32'(count), 32'd3);
    drain(20);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: reset during the second granted word
    grant = 1'b1;
    push_word(8'hF1); tick();
    push_word(8'hF2); tick();
    push_word(8'hF3); tick();
    wr_en = 1'b0;
    chk("t6_drive_2nd", 32'(bus_drive), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("t6_drive", 32'(bus_drive), 32'd0);
    chk("t6_req", 32'(req), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_sent", 32'(sent), 32'd0);
    chk("t6_data", 32'(bus_data), 32'd0);
    tick();
    chk("t6_sent_next", 32'(sent), 32'd0);
    chk("t6_req_next", 32'(req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
